// File: rtl/podule_cycle_ctrl.sv
// podule_cycle_ctrl: sequences every host access to the card's on-board
// devices (ROM, Econet, Ethernet, IDE, interrupt status, flash page latch,
// UART). Latches the decoded region, then runs a SETUP / STROBE / HOLD /
// RECOVER sequence with per-region wait states. It drives the device strobes,
// a read-data capture pulse and the host ready handshake. All outputs are
// registered.
module podule_cycle_ctrl #(
    parameter int unsigned ROM_WAIT    = 3,
    parameter int unsigned ECONET_WAIT = 4,
    parameter int unsigned ETH_WAIT    = 2,
    parameter int unsigned IDE_WAIT    = 5,
    parameter int unsigned REG_WAIT    = 0,
    parameter int unsigned UART_WAIT   = 3,
    parameter int unsigned RECOVERY    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_sel,
    input  logic       host_rnw,
    input  logic       rom_cs,
    input  logic       econet_cs,
    input  logic       ethernet_cs,
    input  logic       ide_cs,
    input  logic       interrupt_cs,
    input  logic       fpl_cs,
    input  logic       uart_cs,
    output logic [6:0] dev_sel,
    output logic       dev_rd,
    output logic       dev_wr,
    output logic       rd_latch,
    output logic       host_ready,
    output logic       busy,
    output logic       err
);

    // The wait and recovery counters are 4 bits wide. Any value that does
    // not fit must stop elaboration rather than wrap silently.
    if (ROM_WAIT > 15 || ECONET_WAIT > 15 || ETH_WAIT > 15 || IDE_WAIT > 15 ||
        REG_WAIT > 15 || UART_WAIT > 15 || RECOVERY > 15) begin : g_param_check
        $error("podule_cycle_ctrl: WAIT/RECOVERY parameters must be 0..15");
    end

    localparam int NUM_REGIONS = 7;

    // Strobe wait table, indexed by dev_sel bit position.
    // The interrupt status and flash page latch both use REG_WAIT.
    localparam logic [3:0] WAIT_TBL [0:NUM_REGIONS-1] = '{
        4'(ROM_WAIT),     // 0: rom
        4'(ECONET_WAIT),  // 1: econet
        4'(ETH_WAIT),     // 2: ethernet
        4'(IDE_WAIT),     // 3: ide
        4'(REG_WAIT),     // 4: interrupt status
        4'(REG_WAIT),     // 5: flash page latch
        4'(UART_WAIT)     // 6: uart
    };

    // RECOVER lasts RECOVERY cycles, so its counter is loaded with
    // RECOVERY-1. A zero recovery bypasses the state entirely.
    localparam logic       REC_ZERO = (RECOVERY == 0);
    localparam logic [3:0] REC_LOAD = REC_ZERO ? 4'd0 : 4'(RECOVERY - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    state_t     state_reg;
    logic [6:0] dev_sel_reg;
    logic       rnw_reg;
    logic [3:0] wait_cnt_reg;
    logic [3:0] rec_cnt_reg;
    logic       dev_rd_reg;
    logic       dev_wr_reg;
    logic       rd_latch_reg;
    logic       host_ready_reg;
    logic       busy_reg;
    logic       err_reg;

    logic [6:0] cs_vec;
    logic       cs_valid;
    logic [3:0] wait_terms [0:NUM_REGIONS-1];
    logic [3:0] wait_load;
    logic       host_abort;

    // Region selects gathered in dev_sel bit order. An access is accepted
    // only when exactly one select is active. Zero or several active
    // selects go down the error path.
    assign cs_vec   = {uart_cs, fpl_cs, interrupt_cs, ide_cs, ethernet_cs, econet_cs, rom_cs};
    assign cs_valid = $onehot(cs_vec);

    // Per-region wait contributions. The latched region is one-hot, so at
    // most one term is non-zero.
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_wait_term
        assign wait_terms[gi] = dev_sel_reg[gi] ? WAIT_TBL[gi] : 4'd0;
    end

    // OR-reduce the per-region terms into the counter load value.
    always_comb begin
        wait_load = 4'd0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            wait_load = wait_load | wait_terms[i];
        end
    end

    // The host abandons a cycle by dropping host_sel before HOLD is reached.
    assign host_abort = !host_sel && (state_reg == ST_SETUP || state_reg == ST_STROBE);

    // Cycle sequencer. Next state and every registered output are updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            dev_sel_reg    <= '0;
            rnw_reg        <= 1'b0;
            wait_cnt_reg   <= '0;
            rec_cnt_reg    <= '0;
            dev_rd_reg     <= 1'b0;
            dev_wr_reg     <= 1'b0;
            rd_latch_reg   <= 1'b0;
            host_ready_reg <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            rd_latch_reg <= 1'b0;
            err_reg      <= 1'b0;

            if (host_abort) begin
                // Kill the device access immediately. Nothing is returned
                // to the host, and the bus still gets its recovery time.
                dev_rd_reg   <= 1'b0;
                dev_wr_reg   <= 1'b0;
                dev_sel_reg  <= '0;
                wait_cnt_reg <= '0;
                err_reg      <= 1'b1;
                if (REC_ZERO) begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end else begin
                    state_reg   <= ST_RECOVER;
                    rec_cnt_reg <= REC_LOAD;
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (host_sel) begin
                            busy_reg <= 1'b1;
                            if (cs_valid) begin
                                dev_sel_reg <= cs_vec;
                                rnw_reg     <= host_rnw;
                                state_reg   <= ST_SETUP;
                            end else begin
                                // Unmapped or ambiguous access: complete it
                                // with no strobe so the host does not stall.
                                dev_sel_reg    <= '0;
                                err_reg        <= 1'b1;
                                host_ready_reg <= 1'b1;
                                state_reg      <= ST_HOLD;
                            end
                        end
                    end

                    ST_SETUP: begin
                        state_reg    <= ST_STROBE;
                        wait_cnt_reg <= wait_load;
                        dev_rd_reg   <= rnw_reg;
                        dev_wr_reg   <= !rnw_reg;
                        // A zero-wait region samples its data in the only strobe cycle.
                        rd_latch_reg <= rnw_reg && (wait_load == 4'd0);
                    end

                    ST_STROBE: begin
                        if (wait_cnt_reg == 4'd0) begin
                            state_reg      <= ST_HOLD;
                            dev_rd_reg     <= 1'b0;
                            dev_wr_reg     <= 1'b0;
                            host_ready_reg <= 1'b1;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg - 4'd1;
                            // Capture in the last strobe cycle, while the
                            // device is still driving data.
                            rd_latch_reg <= rnw_reg && (wait_cnt_reg == 4'd1);
                        end
                    end

                    ST_HOLD: begin
                        if (!host_sel) begin
                            host_ready_reg <= 1'b0;
                            dev_sel_reg    <= '0;
                            if (REC_ZERO) begin
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                            end else begin
                                state_reg   <= ST_RECOVER;
                                rec_cnt_reg <= REC_LOAD;
                            end
                        end
                    end

                    ST_RECOVER: begin
                        // host_sel is ignored here. A new access is only
                        // accepted from IDLE.
                        if (rec_cnt_reg == 4'd0) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            rec_cnt_reg <= rec_cnt_reg - 4'd1;
                        end
                    end

                    default: begin
                        state_reg      <= ST_IDLE;
                        dev_sel_reg    <= '0;
                        dev_rd_reg     <= 1'b0;
                        dev_wr_reg     <= 1'b0;
                        host_ready_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dev_sel    = dev_sel_reg;
    assign dev_rd     = dev_rd_reg;
    assign dev_wr     = dev_wr_reg;
    assign rd_latch   = rd_latch_reg;
    assign host_ready = host_ready_reg;
    assign busy       = busy_reg;
    assign err        = err_reg;

endmodule
